atm_bank_responder: RTL and testbench

//  Bank-side responder for the ATM controller's transaction interface. The ATM FSM issues
//  one request at a time (card, PIN, op, amount). This block authenticates the request,

---
 rtl/atm_pkg.sv | 32 +++
 rtl/atm_bank_responder_if.sv | 29 ++
 rtl/atm_acct_lookup.sv | 27 ++
 rtl/atm_bank_responder.sv | 209 ++++++++++++++++++++
 tb/tb_atm_bank_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM bank responder and its helpers.
package atm_pkg;

  localparam int CARD_W   = 8;
  localparam int PIN_W    = 4;
  localparam int OP_W     = 2;
  localparam int STATUS_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_VERIFY   = 2'd0,
    OP_BALANCE  = 2'd1,
    OP_DEPOSIT  = 2'd2,
    OP_WITHDRAW = 2'd3
  } op_t;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK       = 3'd0,
    ST_BAD_CARD = 3'd1,
    ST_BAD_PIN  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_NO_FUNDS = 3'd4,
    ST_OVERFLOW = 3'd5
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/atm_bank_responder_if.sv
// Request/response handshake between the ATM controller (master) and the bank responder (slave).
interface atm_bank_responder_if #(
  parameter int BAL_W = 5
);
  import atm_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [CARD_W-1:0]   req_card;
  logic [PIN_W-1:0]    req_pin;
  logic [OP_W-1:0]     req_op;
  logic [BAL_W-1:0]    req_amount;

  logic                resp_valid;
  logic                resp_ready;
  logic [STATUS_W-1:0] resp_status;
  logic [BAL_W-1:0]    resp_balance;

  modport master (
    output req_valid, req_card, req_pin, req_op, req_amount, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_balance
  );

  modport slave (
    input  req_valid, req_card, req_pin, req_op, req_amount, resp_ready,
    output req_ready, resp_valid, resp_status, resp_balance
  );

endinterface

// File: rtl/atm_acct_lookup.sv
// Combinational priority match of a card number against the account table.
// The lowest matching entry wins; card 0 never matches anything.
module atm_acct_lookup
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [CARD_W-1:0]                 key,
  input  logic [NUM_ACCTS-1:0][CARD_W-1:0]  cards,
  output logic                              hit,
  output logic [IDX_W-1:0]                  idx
);

  // Scan from the top entry down so the lowest matching index is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
      if ((key != '0) && (cards[i] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/atm_bank_responder.sv
// Bank-side responder: authenticates one ATM request at a time against an
// on-chip account table, applies it and returns a status with the new balance.
module atm_bank_responder
  import atm_pkg::*;
#(
  parameter int  NUM_ACCTS = 4,
  parameter int  BAL_W     = 5,
  parameter int  MAX_TRIES = 3,
  localparam int IDX_W     = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  atm_bank_responder_if.slave bus,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CARD_W-1:0]   cfg_card,
  input  logic [PIN_W-1:0]    cfg_pin,
  input  logic [BAL_W-1:0]    cfg_bal,
  output logic                busy
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  state_t state_q, state_d;

  logic [NUM_ACCTS-1:0][CARD_W-1:0] card_q;
  logic [NUM_ACCTS-1:0][PIN_W-1:0]  pin_q;
  logic [NUM_ACCTS-1:0][BAL_W-1:0]  bal_q;
  logic [NUM_ACCTS-1:0][FAIL_W-1:0] fails_q;
  logic [NUM_ACCTS-1:0]             locked_q;

  logic [CARD_W-1:0] card_l;
  logic [PIN_W-1:0]  pin_l;
  op_t               op_l;
  logic [BAL_W-1:0]  amount_l;

  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q;

  logic              accept;
  logic              cfg_write;

  logic [BAL_W-1:0]  cur_bal;
  logic [PIN_W-1:0]  cur_pin;
  logic [FAIL_W-1:0] cur_fails;
  logic              cur_lock;
  logic [FAIL_W-1:0] fails_inc;
  logic [BAL_W:0]    sum;

  status_t           ex_status;
  logic [BAL_W-1:0]  ex_balance;
  logic [BAL_W-1:0]  ex_bal_new;
  logic [FAIL_W-1:0] ex_fails_new;
  logic              ex_lock_new;

  logic              resp_valid_q;
  status_t           resp_status_q;
  logic [BAL_W-1:0]  resp_balance_q;

  // Provisioning beats requests in IDLE, and nothing is accepted while reset is held
  assign bus.req_ready = (state_q == S_IDLE) && !cfg_we && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign cfg_write     = (state_q == S_IDLE) && cfg_we;
  assign busy          = (state_q != S_IDLE);

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_status  = resp_status_q;
  assign bus.resp_balance = resp_balance_q;

  atm_acct_lookup #(
    .NUM_ACCTS (NUM_ACCTS),
    .IDX_W     (IDX_W)
  ) u_lookup (
    .key   (card_l),
    .cards (card_q),
    .hit   (lk_hit),
    .idx   (lk_idx)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: one request walks IDLE -> LOOKUP -> EXEC -> RESP and back
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the whole request on the handshake so the ATM may change its bus afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_l   <= '0;
      pin_l    <= '0;
      op_l     <= OP_VERIFY;
      amount_l <= '0;
    end else if (accept) begin
      card_l   <= bus.req_card;
      pin_l    <= bus.req_pin;
      op_l     <= op_t'(bus.req_op);
      amount_l <= bus.req_amount;
    end
  end

  // Register the lookup result so EXEC works from a stable entry index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      hit_q <= lk_hit;
      idx_q <= lk_idx;
    end
  end

  // Decide the outcome of the latched request against the selected entry
  always_comb begin
    cur_bal      = bal_q[idx_q];
    cur_pin      = pin_q[idx_q];
    cur_fails    = fails_q[idx_q];
    cur_lock     = locked_q[idx_q];
    fails_inc    = cur_fails + FAIL_W'(1);
    sum          = {1'b0, cur_bal} + {1'b0, amount_l};
    ex_status    = ST_OK;
    ex_balance   = cur_bal;
    ex_bal_new   = cur_bal;
    ex_fails_new = cur_fails;
    ex_lock_new  = cur_lock;
    if (!hit_q) begin
      ex_status  = ST_BAD_CARD;
      ex_balance = '0;
    end else if (cur_lock) begin
      ex_status = ST_LOCKED;
    end else if (pin_l != cur_pin) begin
      ex_status    = ST_BAD_PIN;
      ex_fails_new = fails_inc;
      ex_lock_new  = (fails_inc == FAIL_W'(MAX_TRIES));
    end else begin
      ex_fails_new = '0;
      case (op_l)
        OP_VERIFY, OP_BALANCE: ex_status = ST_OK;
        OP_DEPOSIT: begin
          if (sum[BAL_W]) begin
            ex_status = ST_OVERFLOW;
          end else begin
            ex_bal_new = sum[BAL_W-1:0];
            ex_balance = sum[BAL_W-1:0];
          end
        end
        OP_WITHDRAW: begin
          if (amount_l > cur_bal) begin
            ex_status = ST_NO_FUNDS;
          end else begin
            ex_bal_new = cur_bal - amount_l;
            ex_balance = cur_bal - amount_l;
          end
        end
        default: ex_status = ST_OK;
      endcase
    end
  end

  // Account table: provisioning in IDLE, outcome committed at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_q   <= '0;
      pin_q    <= '0;
      bal_q    <= '0;
      fails_q  <= '0;
      locked_q <= '0;
    end else if (cfg_write) begin
      card_q[cfg_idx]   <= cfg_card;
      pin_q[cfg_idx]    <= cfg_pin;
      bal_q[cfg_idx]    <= cfg_bal;
      fails_q[cfg_idx]  <= '0;
      locked_q[cfg_idx] <= 1'b0;
    end else if ((state_q == S_EXEC) && hit_q) begin
      bal_q[idx_q]    <= ex_bal_new;
      fails_q[idx_q]  <= ex_fails_new;
      locked_q[idx_q] <= ex_lock_new;
    end
  end

  // Response registers: loaded leaving EXEC, held through RESP until the ATM takes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q   <= 1'b0;
      resp_status_q  <= ST_OK;
      resp_balance_q <= '0;
    end else if (state_q == S_EXEC) begin
      resp_valid_q   <= 1'b1;
      resp_status_q  <= ex_status;
      resp_balance_q <= ex_balance;
    end else if ((state_q == S_RESP) && bus.resp_ready) begin
      resp_valid_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Bench for atm_bank_responder: directed scenarios followed by random traffic,
// all checked against an account-level reference model kept here.
module tb_atm_bank_responder;
  import atm_pkg::*;

  localparam int NA = 4;
  localparam int BW = 5;
  localparam int MT = 3;
  localparam int BAL_MAX = (1 << BW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_card;
  logic [3:0] cfg_pin;
  logic [4:0] cfg_bal;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  int m_card [NA];
  int m_pin  [NA];
  int m_bal  [NA];
  int m_fail [NA];
  bit m_lock [NA];

  atm_bank_responder_if #(.BAL_W(BW)) bus ();

  atm_bank_responder #(
    .NUM_ACCTS (NA),
    .BAL_W     (BW),
    .MAX_TRIES (MT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_card (cfg_card),
    .cfg_pin  (cfg_pin),
    .cfg_bal  (cfg_bal),
    .busy     (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case the design never returns to IDLE
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NA; i++) begin
      m_card[i] = 0; m_pin[i] = 0; m_bal[i] = 0; m_fail[i] = 0; m_lock[i] = 1'b0;
    end
  endtask

  task automatic modelCfg(input int idx, input int card, input int pin, input int bal);
    m_card[idx] = card; m_pin[idx] = pin; m_bal[idx] = bal;
    m_fail[idx] = 0;    m_lock[idx] = 1'b0;
  endtask

  // Account-level behaviour of one request; updates the model table
  task automatic modelReq(input int card, input int pin, input int op, input int amt,
                          output int st, output int bl);
    int hit;
    hit = -1;
    for (int i = 0; i < NA; i++)
      if (hit < 0 && card != 0 && m_card[i] == card) hit = i;
    if (hit < 0) begin
      st = ST_BAD_CARD; bl = 0;
    end else if (m_lock[hit]) begin
      st = ST_LOCKED; bl = m_bal[hit];
    end else if (pin != m_pin[hit]) begin
      m_fail[hit] = m_fail[hit] + 1;
      if (m_fail[hit] == MT) m_lock[hit] = 1'b1;
      st = ST_BAD_PIN; bl = m_bal[hit];
    end else begin
      m_fail[hit] = 0;
      st = ST_OK;
      if (op == OP_DEPOSIT) begin
        if (m_bal[hit] + amt > BAL_MAX) st = ST_OVERFLOW;
        else m_bal[hit] = m_bal[hit] + amt;
      end else if (op == OP_WITHDRAW) begin
        if (amt > m_bal[hit]) st = ST_NO_FUNDS;
        else m_bal[hit] = m_bal[hit] - amt;
      end
      bl = m_bal[hit];
    end
  endtask

  // Provision one entry from IDLE, optionally with a competing request in the same cycle
  task automatic doCfg(input int idx, input int card, input int pin, input int bal, input bit with_req);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_card = card[7:0]; cfg_pin = pin[3:0]; cfg_bal = bal[4:0];
    if (with_req) begin
      bus.req_valid = 1'b1; bus.req_card = card[7:0]; bus.req_pin = pin[3:0];
      bus.req_op = 2'(OP_BALANCE); bus.req_amount = '0;
    end
    #1;
    checkOutput("cfg_blocks_req_ready", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("cfg_no_accept_busy", busy, 0);
    modelCfg(idx, card, pin, bal);
  endtask

  // One full request/response transaction with optional response back-pressure
  task automatic applyStimulus(input int card, input int pin, input int op, input int amt,
                               input int hold, input bit busy_cfg,
                               output int ost, output int obal);
    int est, ebal, lat;
    modelReq(card, pin, op, amt, est, ebal);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_card = card[7:0]; bus.req_pin = pin[3:0];
    bus.req_op = op[1:0]; bus.req_amount = amt[4:0];
    #1;
    checkOutput("req_ready_idle", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_card = 8'($urandom); bus.req_pin = 4'($urandom);
    bus.req_op = 2'($urandom); bus.req_amount = 5'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, 3);
    ost  = int'(bus.resp_status);
    obal = int'(bus.resp_balance);
    checkOutput("status", ost, est);
    checkOutput("balance", obal, ebal);
    for (int k = 0; k < hold; k++) begin
      checkOutput("hold_valid", bus.resp_valid, 1);
      checkOutput("hold_req_ready", bus.req_ready, 0);
      checkOutput("hold_busy", busy, 1);
      if (busy_cfg && k == 0) begin
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_card = 8'h99; cfg_pin = 4'h0; cfg_bal = 5'd0;
      end
      @(negedge clk);
      cfg_we = 1'b0;
      checkOutput("hold_status", bus.resp_status, est);
      checkOutput("hold_balance", bus.resp_balance, ebal);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checkOutput("resp_cleared", bus.resp_valid, 0);
    checkOutput("idle_after_resp", busy, 0);
  endtask

  initial begin
    int st, bl, sel, card, pin, op, amt, hold;
    int prov [NA];

    rst = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_card = '0; cfg_pin = '0; cfg_bal = '0;
    bus.req_valid = 1'b0; bus.req_card = '0; bus.req_pin = '0; bus.req_op = '0; bus.req_amount = '0;
    bus.resp_ready = 1'b0;
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_resp_status", bus.resp_status, 0);
    checkOutput("rst_resp_balance", bus.resp_balance, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req_ready", bus.req_ready, 1);

    // Basic withdraw
    doCfg(0, 8'h21, 4'h7, 10, 1'b0);
    applyStimulus(8'h21, 4'h7, OP_WITHDRAW, 4, 0, 1'b0, st, bl);
    checkOutput("t1_status", st, ST_OK);
    checkOutput("t1_balance", bl, 6);

    // Unknown cards, then the real account is untouched
    applyStimulus(8'h55, 4'h7, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t2_unprov_status", st, ST_BAD_CARD);
    checkOutput("t2_unprov_balance", bl, 0);
    applyStimulus(8'h00, 4'h0, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t2_card0_status", st, ST_BAD_CARD);
    applyStimulus(8'h21, 4'h7, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t2_unchanged_balance", bl, 6);

    // PIN lockout and unlock by reprovisioning
    for (int i = 0; i < MT; i++) begin
      applyStimulus(8'h21, 4'h3, OP_VERIFY, 0, 0, 1'b0, st, bl);
      checkOutput("t3_bad_pin", st, ST_BAD_PIN);
    end
    applyStimulus(8'h21, 4'h7, OP_VERIFY, 0, 0, 1'b0, st, bl);
    checkOutput("t3_locked", st, ST_LOCKED);
    doCfg(0, 8'h21, 4'h7, 10, 1'b0);
    applyStimulus(8'h21, 4'h7, OP_VERIFY, 0, 0, 1'b0, st, bl);
    checkOutput("t3_unlocked", st, ST_OK);

    // Balance boundaries
    doCfg(1, 8'h33, 4'h2, 30, 1'b0);
    applyStimulus(8'h33, 4'h2, OP_DEPOSIT, 5, 0, 1'b0, st, bl);
    checkOutput("t4_overflow", st, ST_OVERFLOW);
    checkOutput("t4_overflow_bal", bl, 30);
    applyStimulus(8'h33, 4'h2, OP_WITHDRAW, 31, 0, 1'b0, st, bl);
    checkOutput("t4_no_funds", st, ST_NO_FUNDS);
    applyStimulus(8'h33, 4'h2, OP_WITHDRAW, 30, 0, 1'b0, st, bl);
    checkOutput("t4_drain_status", st, ST_OK);
    checkOutput("t4_drain_bal", bl, 0);
    applyStimulus(8'h33, 4'h2, OP_DEPOSIT, 0, 0, 1'b0, st, bl);
    checkOutput("t4_zero_amount", st, ST_OK);
    applyStimulus(8'h33, 4'h2, OP_DEPOSIT, 31, 0, 1'b0, st, bl);
    checkOutput("t4_fill_bal", bl, 31);

    // Duplicate card: lowest entry answers
    doCfg(2, 8'h33, 4'h9, 1, 1'b1);
    applyStimulus(8'h33, 4'h2, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t4_dup_lowest", bl, 31);

    // Back-pressure with a dropped provisioning attempt
    applyStimulus(8'h21, 4'h7, OP_BALANCE, 0, 5, 1'b1, st, bl);
    checkOutput("t5_balance", bl, 10);
    applyStimulus(8'h21, 4'h7, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t5_cfg_dropped", st, ST_OK);

    // Reset in the middle of a deposit
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_card = 8'h21; bus.req_pin = 4'h7;
    bus.req_op = 2'(OP_DEPOSIT); bus.req_amount = 5'd3;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy_in_exec", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_req_ready", bus.req_ready, 0);
    checkOutput("t6_resp_valid", bus.resp_valid, 0);
    checkOutput("t6_resp_status", bus.resp_status, 0);
    checkOutput("t6_resp_balance", bus.resp_balance, 0);
    checkOutput("t6_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(8'h21, 4'h7, OP_BALANCE, 0, 0, 1'b0, st, bl);
    checkOutput("t6_entry_cleared", st, ST_BAD_CARD);
    checkOutput("t6_entry_bal", bl, 0);

    // Random traffic against the model
    for (int i = 0; i < NA; i++) begin
      prov[i] = 8'h40 + $urandom_range(0, 3);
      doCfg(i, prov[i], $urandom_range(0, 2), $urandom_range(0, BAL_MAX), 1'b0);
    end
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        sel = $urandom_range(0, NA - 1);
        doCfg(sel, 8'h40 + $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, BAL_MAX), 1'($urandom));
      end
      sel  = $urandom_range(0, 4);
      card = (sel == 4) ? 0 : 8'h40 + sel;
      pin  = $urandom_range(0, 2);
      op   = $urandom_range(0, 3);
      amt  = $urandom_range(0, BAL_MAX);
      hold = $urandom_range(0, 2);
      applyStimulus(card, pin, op, amt, hold, 1'b0, st, bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
